// File: rtl/div_iter.sv
// Iterative 32-bit radix-2 restoring divider (DIV/DIVU) for the EX stage.
// Produces {remainder, quotient}, holds it until start_i drops, and is cancelled by annul_i.
module div_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    typedef enum logic [1:0] {
        FREE,
        BYZERO,
        ON,
        END
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   dvd;
    logic [WIDTH-1:0]   divisor;
    logic               s1;
    logic               s2;

    logic               neg1;
    logic               neg2;
    logic [WIDTH-1:0]   abs1;
    logic [WIDTH-1:0]   abs2;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign neg1 = signed_div_i & opdata1_i[WIDTH-1];
    assign neg2 = signed_div_i & opdata2_i[WIDTH-1];
    assign abs1 = neg1 ? ({WIDTH{1'b0}} - opdata1_i) : opdata1_i;
    assign abs2 = neg2 ? ({WIDTH{1'b0}} - opdata2_i) : opdata2_i;

    // dvd doubles as the quotient: dividend bits shift out the top while quotient bits enter below.
    assign shifted = {rem, dvd[WIDTH-1]};
    assign trial   = shifted - {1'b0, divisor};

    // Quotient sign follows s1^s2; the remainder takes the dividend's sign.
    assign quo_fix = (s1 ^ s2) ? ({WIDTH{1'b0}} - dvd) : dvd;
    assign rem_fix = s1 ? ({WIDTH{1'b0}} - rem) : rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            cnt      <= '0;
            rem      <= '0;
            dvd      <= '0;
            divisor  <= '0;
            s1       <= 1'b0;
            s2       <= 1'b0;
            ready_o  <= 1'b0;
            result_o <= '0;
        end else if (annul_i) begin
            state    <= FREE;
            cnt      <= '0;
            ready_o  <= 1'b0;
            result_o <= '0;
        end else begin
            case (state)
                FREE: begin
                    if (start_i) begin
                        s1      <= neg1;
                        s2      <= neg2;
                        dvd     <= abs1;
                        divisor <= abs2;
                        rem     <= '0;
                        cnt     <= '0;
                        state   <= (opdata2_i == '0) ? BYZERO : ON;
                    end
                end
                BYZERO: begin
                    state    <= END;
                    ready_o  <= 1'b1;
                    result_o <= '0;
                end
                ON: begin
                    // After WIDTH steps the count triggers one extra edge that registers the sign-fixed result.
                    if (cnt != CNT_W'(WIDTH)) begin
                        rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                        dvd <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        state    <= END;
                        ready_o  <= 1'b1;
                        result_o <= {rem_fix, quo_fix};
                    end
                end
                END: begin
                    if (!start_i) begin
                        state    <= FREE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end
                default: state <= FREE;
            endcase
        end
    end

endmodule
